serial_word_receiver: RTL and testbench

- Serial-to-parallel receiver: the receive end of the 8-bit shift-register serial link.
- Takes one framed bit stream, qualified by a bit strobe. Frame format: idle-high line, start bit 0, WIDTH data bits, optional parity bit, stop bit 1.
- Reassembles each frame into a parallel word, presented through a valid/ready holding register.
- Bit order is selectable to match the transmitter's shift direction: LSB-first for right shift, MSB-first for left shift.

---
 rtl/serial_word_receiver.sv | 107 ++++++++++
 tb/tb_serial_word_receiver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start/data/optional parity/stop, bit-strobe qualified,
// selectable bit order, result presented through a valid/ready holding register.
module serial_word_receiver #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             bit_en,
  input  logic             dir,
  input  logic             parity_en,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  // state  | meaning
  // IDLE   | line idle, waiting for a start bit (sin=0)
  // DATA   | shifting in WIDTH data bits
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit and delivering/rejecting the word
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic             par_q;
  logic             par_bad;

  always_comb begin
    sr_next = sr;
    if (dir_q) sr_next = {sr[WIDTH-2:0], sin};
    else       sr_next = {sin, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      dir_q      <= 1'b0;
      par_q      <= 1'b0;
      par_bad    <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (o_valid && o_ready) o_valid <= 1'b0;

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!sin) begin
              state   <= DATA;
              busy    <= 1'b1;
              dir_q   <= dir;
              par_q   <= parity_en;
              cnt     <= '0;
              sr      <= '0;
              par_bad <= 1'b0;
            end
          end
          DATA: begin
            sr  <= sr_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= par_q ? PARITY : STOP;
          end
          PARITY: begin
            par_bad <= ((^sr) ^ sin) != PARITY_ODD;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            // a word completing while the old one is consumed replaces it without overrun
            if (!sin)                      frame_err  <= 1'b1;
            else if (par_bad)              parity_err <= 1'b1;
            else if (!o_valid || o_ready) begin
              o_data  <= sr;
              o_valid <= 1'b1;
            end else                       overrun    <= 1'b1;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: drives framed bit streams and checks the
// delivered words, handshake and error pulses against hand-computed values.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       reset, sin, bit_en, dir, parity_en, o_ready;
  logic [7:0] o_data;
  logic       o_valid, busy, frame_err, parity_err, overrun;

  int n_checks = 0;
  int n_errors = 0;

  serial_word_receiver #(.WIDTH(8), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .sin(sin), .bit_en(bit_en), .dir(dir),
    .parity_en(parity_en), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap idle cycles first, then one strobed bit; returns just after the sampling edge
  task automatic drive_bit(input logic b, input int gap);
    repeat (gap) tick();
    sin    = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic send_start(input logic d, input logic pe, input int gap);
    dir       = d;
    parity_en = pe;
    drive_bit(1'b0, gap);
  endtask

  task automatic send_data(input logic d, input logic [7:0] w, input int gap);
    for (int i = 0; i < 8; i++) drive_bit(d ? w[7-i] : w[i], gap);
  endtask

  task automatic send_frame(input logic d, input logic pe, input logic [7:0] w,
                            input logic pbit, input logic stop, input int gap);
    send_start(d, pe, gap);
    send_data(d, w, gap);
    if (pe) drive_bit(pbit, gap);
    drive_bit(stop, gap);
  endtask

  initial begin
    reset = 1'b1; sin = 1'b1; bit_en = 1'b0; dir = 1'b0; parity_en = 1'b0; o_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {frame_err, parity_err, overrun}, 3'b000);

    // LSB-first, no parity
    send_frame(1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 0);
    chk("lsb_data", o_data, 8'hA5);
    chk("lsb_valid", o_valid, 1);
    chk("lsb_errs", {frame_err, parity_err, overrun}, 3'b000);
    tick();
    chk("lsb_valid_drop", o_valid, 0);

    // MSB-first, strobe every 3rd cycle; dir flipped mid-frame must be ignored
    send_start(1'b1, 1'b0, 2);
    chk("msb_busy_start", busy, 1);
    dir = 1'b0;
    send_data(1'b1, 8'h7B, 2);
    chk("msb_busy_data", busy, 1);
    drive_bit(1'b1, 2);
    chk("msb_busy_end", busy, 0);
    chk("msb_data", o_data, 8'h7B);
    chk("msb_valid", o_valid, 1);
    tick();

    // even parity, good then bad
    send_frame(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 0);
    chk("par_ok_data", o_data, 8'hA5);
    chk("par_ok_valid", o_valid, 1);
    chk("par_ok_perr", parity_err, 0);
    tick();
    send_frame(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 0);
    chk("par_bad_perr", parity_err, 1);
    chk("par_bad_valid", o_valid, 0);
    tick();
    chk("par_bad_pulse", parity_err, 0);

    // framing error then recovery
    send_frame(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0);
    chk("ferr_pulse", frame_err, 1);
    chk("ferr_valid", o_valid, 0);
    send_frame(1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 0);
    chk("ferr_next_data", o_data, 8'h81);
    chk("ferr_next_valid", o_valid, 1);
    chk("ferr_next_clear", frame_err, 0);
    tick();

    // backpressure and overrun
    o_ready = 1'b0;
    send_frame(1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 0);
    chk("bp_first_data", o_data, 8'h11);
    chk("bp_first_valid", o_valid, 1);
    send_frame(1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 0);
    chk("bp_overrun", overrun, 1);
    chk("bp_held_data", o_data, 8'h11);
    chk("bp_held_valid", o_valid, 1);
    tick();
    chk("bp_overrun_pulse", overrun, 0);
    chk("bp_still_valid", o_valid, 1);

    // consume and refill on the same edge
    send_start(1'b0, 1'b0, 0);
    send_data(1'b0, 8'h33, 0);
    o_ready = 1'b1;
    drive_bit(1'b1, 0);
    chk("swap_data", o_data, 8'h33);
    chk("swap_valid", o_valid, 1);
    chk("swap_no_overrun", overrun, 0);
    tick();
    chk("swap_drain", o_valid, 0);

    // reset mid-frame, back-to-back recovery frame
    send_start(1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
    chk("rmid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_busy", busy, 0);
    chk("rmid_valid", o_valid, 0);
    chk("rmid_data", o_data, 8'h00);
    send_frame(1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 0);
    chk("rmid_next_data", o_data, 8'h5A);
    chk("rmid_next_valid", o_valid, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
